// File: rtl/ceyloniac_regfile_debug_controller.sv
`default_nettype none
// ============================================================================
// Module   : ceyloniac_regfile_debug_controller
// Brief    : Sequences host read/write/clear-all access to the register file
//            by halting the core and taking over its external control port.
// Revision : 1.0
// ============================================================================
module ceyloniac_regfile_debug_controller #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int HALT_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_req,
    input  logic [1:0]            host_cmd,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic                  host_err,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  busy,
    output logic                  core_halt_req,
    input  logic                  core_halted,
    output logic                  reg_external_control_enable,
    output logic [ADDR_WIDTH-1:0] external_read_addr1,
    output logic [ADDR_WIDTH-1:0] external_write_addr,
    output logic [DATA_WIDTH-1:0] external_write_data,
    output logic                  external_write_enable,
    input  logic [DATA_WIDTH-1:0] read_data1
);

    localparam int c_TO_W = (HALT_TIMEOUT < 2) ? 1 : $clog2(HALT_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0]     c_TIMEOUT  = c_TO_W'(HALT_TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    localparam logic [1:0] c_CMD_READ  = 2'b00;
    localparam logic [1:0] c_CMD_WRITE = 2'b01;
    localparam logic [1:0] c_CMD_CLEAR = 2'b10;
    localparam logic [1:0] c_CMD_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HALT_WAIT = 3'd1,
        S_ACCESS    = 3'd2,
        S_CLEAR     = 3'd3,
        S_RESPOND   = 3'd4,
        S_RELEASE   = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [1:0]              r_cmd;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_TO_W-1:0]       r_to_cnt;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic                    r_err;
    logic                    r_halt_req;
    logic                    r_ext_en;
    logic [DATA_WIDTH-1:0]   r_rdata;

    assign host_rdata                  = r_rdata;
    assign core_halt_req               = r_halt_req;
    assign reg_external_control_enable = r_ext_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next          = r_state;
        busy                  = (r_state != S_IDLE);
        host_ack              = 1'b0;
        host_err              = 1'b0;
        external_read_addr1   = '0;
        external_write_addr   = '0;
        external_write_data   = '0;
        external_write_enable = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (host_req) begin
                    w_state_next = (host_cmd == c_CMD_RSVD) ? S_RESPOND : S_HALT_WAIT;
                end
            end
            S_HALT_WAIT: begin
                if (core_halted) begin
                    w_state_next = (r_cmd == c_CMD_CLEAR) ? S_CLEAR : S_ACCESS;
                end else if (r_to_cnt == c_TIMEOUT) begin
                    w_state_next = S_RESPOND;
                end
            end
            S_ACCESS: begin
                w_state_next = S_RESPOND;
                if (r_cmd == c_CMD_READ) begin
                    external_read_addr1 = r_addr;
                end
                if (r_cmd == c_CMD_WRITE) begin
                    external_write_addr   = r_addr;
                    external_write_data   = r_wdata;
                    external_write_enable = 1'b1;
                end
            end
            S_CLEAR: begin
                external_write_addr = r_idx;
                // A core that leaves halt mid-clear must not see this cycle's write.
                external_write_enable = core_halted;
                if (!core_halted || (r_idx == c_LAST_IDX)) begin
                    w_state_next = S_RESPOND;
                end
            end
            S_RESPOND: begin
                host_ack     = 1'b1;
                host_err     = r_err;
                w_state_next = S_RELEASE;
            end
            S_RELEASE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd      <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_to_cnt   <= '0;
            r_idx      <= '0;
            r_err      <= 1'b0;
            r_halt_req <= 1'b0;
            r_ext_en   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (host_req) begin
                        r_cmd    <= host_cmd;
                        r_addr   <= host_addr;
                        r_wdata  <= host_wdata;
                        r_to_cnt <= '0;
                        r_idx    <= '0;
                        if (host_cmd == c_CMD_RSVD) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err      <= 1'b0;
                            r_halt_req <= 1'b1;
                        end
                    end
                end
                S_HALT_WAIT: begin
                    if (core_halted) begin
                        r_ext_en <= 1'b1;
                    end else if (r_to_cnt == c_TIMEOUT) begin
                        r_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end
                S_ACCESS: begin
                    if (r_cmd == c_CMD_READ) begin
                        r_rdata <= read_data1;
                    end
                end
                S_CLEAR: begin
                    if (!core_halted) begin
                        r_err <= 1'b1;
                    end else begin
                        r_idx <= r_idx + ADDR_WIDTH'(1);
                    end
                end
                S_RESPOND: begin
                    // Enable and halt request both drop on entry to RELEASE.
                    r_ext_en   <= 1'b0;
                    r_halt_req <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    a_en_needs_halt: assert property (@(posedge clk) disable iff (reset)
        reg_external_control_enable |-> core_halt_req);

    a_ack_single: assert property (@(posedge clk) disable iff (reset)
        host_ack |=> !host_ack);

endmodule
`default_nettype wire
